// File: rtl/dest_reg_pipe_pkg.sv
// Shared definitions for the destination-register tracking pipeline.
// The network-write FSM states and the "no destination" register specifier.
package dest_reg_pipe_pkg;

    typedef enum logic [1:0] {
        NET_NORMAL = 2'd0,
        NET_DRAIN  = 2'd1,
        NET_GRANT  = 2'd2
    } net_fsm_e;

    // Register 0 is never a real destination, so it marks an empty slot.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/dest_reg_pipe_sat_counter.sv
// Saturating up-counter with synchronous clear.
// The clear wins over an increment that arrives in the same cycle.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dest_reg_pipe.sv
// Tracks the destination register of in-flight instructions through EX, M and WB,
// and interlocks network register writes by draining the pipe before granting.
module dest_reg_pipe
    import dest_reg_pipe_pkg::*;
#(
    parameter int reg_width = 6,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 dec_valid_i,
    input  logic                 dec_wen_i,
    input  logic [reg_width-1:0] dec_op_dest_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 net_reg_write_cmd_i,
    input  logic                 clear_count_i,
    output logic [reg_width-1:0] ex_op_dest_o,
    output logic [reg_width-1:0] m_op_dest_o,
    output logic [reg_width-1:0] wb_op_dest_o,
    output logic                 wb_wen_o,
    output logic                 pipe_empty_o,
    output logic                 net_busy_o,
    output logic                 net_grant_o,
    output logic [CNT_W-1:0]     bubble_count_o
);

    localparam logic [reg_width-1:0] ZERO_DEST = reg_width'(REG_ZERO);

    logic [reg_width-1:0] ex_q, ex_d;
    logic [reg_width-1:0] m_q, m_d;
    logic [reg_width-1:0] wb_q, wb_d;
    net_fsm_e             state_q, state_d;
    logic                 issue;
    logic                 blocked;
    logic                 bubble;

    // Issue / bubble decision. An idle decode is only a bubble while the FSM
    // holds decode off; a valid non-writing instruction never counts.
    always_comb begin
        blocked = stall_i | flush_i | (state_q != NET_NORMAL);
        issue   = dec_valid_i & dec_wen_i & ~blocked;
        bubble  = (dec_valid_i & dec_wen_i & blocked) |
                  (~dec_valid_i & (state_q != NET_NORMAL));
        ex_d    = issue ? dec_op_dest_i : ZERO_DEST;
        m_d     = ex_q;
        wb_d    = m_q;
    end

    always_comb begin
        state_d     = state_q;
        net_busy_o  = 1'b0;
        net_grant_o = 1'b0;
        case (state_q)
            NET_NORMAL: begin
                if (net_reg_write_cmd_i) state_d = NET_DRAIN;
            end
            NET_DRAIN: begin
                net_busy_o = 1'b1;
                if (pipe_empty_o) state_d = NET_GRANT;
            end
            NET_GRANT: begin
                net_busy_o  = 1'b1;
                net_grant_o = 1'b1;
                state_d     = NET_NORMAL;
            end
            default: state_d = NET_NORMAL;
        endcase
    end

    // Older stages always advance; only the EX load is gated.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ex_q    <= ZERO_DEST;
            m_q     <= ZERO_DEST;
            wb_q    <= ZERO_DEST;
            state_q <= NET_NORMAL;
        end else begin
            ex_q    <= ex_d;
            m_q     <= m_d;
            wb_q    <= wb_d;
            state_q <= state_d;
        end
    end

    assign ex_op_dest_o = ex_q;
    assign m_op_dest_o  = m_q;
    assign wb_op_dest_o = wb_q;
    assign wb_wen_o     = (wb_q != ZERO_DEST);
    assign pipe_empty_o = (ex_q == ZERO_DEST) && (m_q == ZERO_DEST) && (wb_q == ZERO_DEST);

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .n_reset (n_reset),
        .inc_i   (bubble),
        .clr_i   (clear_count_i),
        .count_o (bubble_count_o)
    );

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe; a delay-line scoreboard checks WB against issued EX values.
module tb_dest_reg_pipe;

    localparam int RW = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          dec_valid_i, dec_wen_i, stall_i, flush_i, net_reg_write_cmd_i, clear_count_i;
    logic [RW-1:0] dec_op_dest_i;
    logic [RW-1:0] ex_op_dest_o, m_op_dest_o, wb_op_dest_o;
    logic          wb_wen_o, pipe_empty_o, net_busy_o, net_grant_o;
    logic [CW-1:0] bubble_count_o;

    int total = 0;
    int bad   = 0;
    int sb[$];

    always #5 clk = ~clk;

    dest_reg_pipe #(.reg_width(RW), .CNT_W(CW)) dut (
        .clk                 (clk),
        .n_reset             (n_reset),
        .dec_valid_i         (dec_valid_i),
        .dec_wen_i           (dec_wen_i),
        .dec_op_dest_i       (dec_op_dest_i),
        .stall_i             (stall_i),
        .flush_i             (flush_i),
        .net_reg_write_cmd_i (net_reg_write_cmd_i),
        .clear_count_i       (clear_count_i),
        .ex_op_dest_o        (ex_op_dest_o),
        .m_op_dest_o         (m_op_dest_o),
        .wb_op_dest_o        (wb_op_dest_o),
        .wb_wen_o            (wb_wen_o),
        .pipe_empty_o        (pipe_empty_o),
        .net_busy_o          (net_busy_o),
        .net_grant_o         (net_grant_o),
        .bubble_count_o      (bubble_count_o)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_net(input string tag, input int busy, input int grant);
        chk({tag, "_busy"}, int'(net_busy_o), busy);
        chk({tag, "_grant"}, int'(net_grant_o), grant);
    endtask

    // One clock: drive inputs, wait for the edge, check EX and the WB scoreboard.
    task automatic step(input logic v, input logic w, input int d, input logic st,
                        input logic fl, input logic cmd, input logic clr, input int exp_ex);
        dec_valid_i         = v;
        dec_wen_i           = w;
        dec_op_dest_i       = RW'(d);
        stall_i             = st;
        flush_i             = fl;
        net_reg_write_cmd_i = cmd;
        clear_count_i       = clr;
        @(posedge clk);
        #1;
        chk("ex", int'(ex_op_dest_o), exp_ex);
        sb.push_back(exp_ex);
        if (sb.size() == 3) chk("wb_sb", int'(wb_op_dest_o), sb.pop_front());
    endtask

    task automatic idle(input int exp_ex);
        step(0, 0, 0, 0, 0, 0, 0, exp_ex);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ex"}, int'(ex_op_dest_o), 0);
        chk({tag, "_m"}, int'(m_op_dest_o), 0);
        chk({tag, "_wb"}, int'(wb_op_dest_o), 0);
        chk({tag, "_wen"}, int'(wb_wen_o), 0);
        chk({tag, "_empty"}, int'(pipe_empty_o), 1);
        chk_net(tag, 0, 0);
        chk({tag, "_cnt"}, int'(bubble_count_o), 0);
    endtask

    initial begin
        n_reset = 1'b0;
        dec_valid_i = 0; dec_wen_i = 0; dec_op_dest_i = '0; stall_i = 0; flush_i = 0;
        net_reg_write_cmd_i = 0; clear_count_i = 0;
        #12;
        chk_reset_state("rst");
        n_reset = 1'b1;

        // back-to-back issue: WB shows 5,7,9 three cycles after each issue
        step(1, 1, 5, 0, 0, 0, 0, 5);
        step(1, 1, 7, 0, 0, 0, 0, 7);
        chk("m_5", int'(m_op_dest_o), 5);
        step(1, 1, 9, 0, 0, 0, 0, 9);
        chk("wen_5", int'(wb_wen_o), 1);
        idle(0);
        idle(0);
        idle(0);
        chk("empty_after_drain", int'(pipe_empty_o), 1);
        chk("cnt_no_bubbles", int'(bubble_count_o), 0);

        // stall holds dest 6 for two cycles, two bubbles counted
        step(1, 1, 5, 0, 0, 0, 0, 5);
        step(1, 1, 6, 1, 0, 0, 0, 0);
        step(1, 1, 6, 1, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0, 6);
        chk("cnt_stall", int'(bubble_count_o), 2);
        step(1, 0, 11, 0, 0, 0, 0, 0);
        chk("cnt_nowen", int'(bubble_count_o), 2);
        idle(0); idle(0); idle(0);

        // flush kills dest 12 before EX
        step(1, 1, 12, 0, 1, 0, 0, 0);
        chk("cnt_flush", int'(bubble_count_o), 3);
        idle(0); idle(0); idle(0);

        // drain with dest 3 in flight, then one-cycle grant
        step(1, 1, 3, 0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk_net("drain0", 1, 0);
        idle(0);
        chk_net("drain1", 1, 0);
        chk("drain_wb3", int'(wb_op_dest_o), 3);
        idle(0);
        chk_net("drain2", 1, 0);
        idle(0);
        chk_net("grant", 1, 1);
        idle(0);
        chk_net("post_grant", 0, 0);
        chk("cnt_drain", int'(bubble_count_o), 7);

        // empty pipe, cmd held: DRAIN, GRANT, NORMAL, DRAIN again
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk_net("e_drain", 1, 0);
        step(1, 1, 20, 0, 0, 1, 0, 0);
        chk_net("e_grant", 1, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk_net("e_normal", 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk_net("e_redrain", 1, 0);
        idle(0);
        chk_net("e_regrant", 1, 1);
        idle(0);
        chk_net("e_done", 0, 0);

        // saturation at 2^CW-1, clear priority over increment
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("cnt_clr", int'(bubble_count_o), 0);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 0, 0, 0, 0);
        chk("cnt_sat", int'(bubble_count_o), 15);
        step(1, 1, 1, 1, 0, 0, 1, 0);
        chk("cnt_clr_prio", int'(bubble_count_o), 0);
        step(1, 1, 1, 1, 0, 0, 0, 0);
        chk("cnt_after_clr", int'(bubble_count_o), 1);
        idle(0); idle(0); idle(0);

        // async reset in the middle of a drain
        step(1, 1, 4, 0, 0, 0, 0, 4);
        step(1, 1, 8, 0, 0, 0, 0, 8);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk_net("pre_rst", 1, 0);
        chk("pre_rst_wb", int'(wb_op_dest_o), 4);
        #2 n_reset = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        #2 n_reset = 1'b1;
        sb.delete();
        idle(0);
        chk_net("rst_normal", 0, 0);
        step(1, 1, 13, 0, 0, 0, 0, 13);
        idle(0);
        idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
